// File: rtl/stream_prefetcher_pkg.sv
// Shared types and helpers for the multi-stream sequential prefetcher.
// Optional build macro PREF_PERF_CNT_EN is consumed by stream_table and stream_prefetcher.
package stream_pref_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    FILL  = 2'd2
  } pref_state_e;

  localparam logic DIR_ASC  = 1'b0;
  localparam logic DIR_DESC = 1'b1;

  // Line numbers are kept 32 bits wide; the upper OFFSET bits are always zero.
  typedef struct packed {
    logic        valid;
    logic        dir;
    logic [7:0]  cnt;
    logic [31:0] last;
    logic [31:0] next;
  } stream_entry_t;

  function automatic logic step_blocked(input logic [31:0] line, input logic dir,
                                        input logic [31:0] max_line);
    return (dir == DIR_ASC) ? (line == max_line) : (line == 32'd0);
  endfunction

  function automatic logic [31:0] step_line(input logic [31:0] line, input logic dir);
    return (dir == DIR_ASC) ? (line + 32'd1) : (line - 32'd1);
  endfunction

endpackage

// File: rtl/stream_prefetcher_if.sv
// Prefetch memory request/response and cache fill bus of the stream prefetcher.
interface stream_prefetcher_if #(parameter int unsigned LINE_W = 256);
  logic              pref_pmem_read_cla;
  logic              pref_pmem_write_cla;
  logic [31:0]       pref_pmem_address_cla;
  logic [LINE_W-1:0] pref_pmem_wdata_cla;
  logic              pref_pmem_resp_cla;
  logic [LINE_W-1:0] pref_pmem_rdata_cla;
  logic              pref_fill_valid;
  logic [31:0]       pref_fill_addr;
  logic [LINE_W-1:0] pref_fill_data;

  modport master (
    output pref_pmem_read_cla, pref_pmem_write_cla, pref_pmem_address_cla, pref_pmem_wdata_cla,
    output pref_fill_valid, pref_fill_addr, pref_fill_data,
    input  pref_pmem_resp_cla, pref_pmem_rdata_cla
  );

  modport slave (
    input  pref_pmem_read_cla, pref_pmem_write_cla, pref_pmem_address_cla, pref_pmem_wdata_cla,
    input  pref_fill_valid, pref_fill_addr, pref_fill_data,
    output pref_pmem_resp_cla, pref_pmem_rdata_cla
  );
endinterface

// File: rtl/stream_prefetcher_table.sv
// Stream table: direction training, round-robin allocation/issue selection, stale tracking.
// PREF_PERF_CNT_EN exposes the stale flag for the performance counters.
module stream_table
  import stream_pref_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = 4,
  parameter int unsigned LIMIT       = 8,
  parameter int unsigned OFFSET      = 5,
  localparam int unsigned IDX_W      = $clog2(NUM_STREAMS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             train_en,
  input  logic [31:0]      train_line,
  input  logic             start,
  input  logic             issuing,
  input  logic             fill_en,
  input  logic [IDX_W-1:0] infl_idx,
  input  logic             infl_dir,
  output logic             sel_valid,
  output logic [IDX_W-1:0] sel_idx,
  output logic [31:0]      sel_next,
  output logic             sel_dir
`ifdef PREF_PERF_CNT_EN
  ,
  output logic             stale
`endif
);

  localparam logic [31:0]      MAX_LINE  = 32'hFFFF_FFFF >> OFFSET;
  localparam logic [7:0]       CNT_LIMIT = 8'(LIMIT);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  stream_entry_t    tbl_q [NUM_STREAMS];
  logic [IDX_W-1:0] alloc_ptr_q;
  logic [IDX_W-1:0] issue_ptr_q;
  logic             stale_q;

  logic             hit_inc, hit_dec, hit_rep;
  logic [IDX_W-1:0] idx_inc, idx_dec;
  logic             train_wr, alloc_adv, train_blocked;
  logic [IDX_W-1:0] train_idx;
  logic             new_dir;
  stream_entry_t    new_ent;
  logic             fill_blocked;
  logic [31:0]      fill_next;
  logic [7:0]       fill_cnt;
  logic [IDX_W-1:0] cand;

  // Lowest index wins within each match class; the last != MAX/0 guards keep +-1 from wrapping.
  always_comb begin
    hit_inc = 1'b0;
    hit_dec = 1'b0;
    hit_rep = 1'b0;
    idx_inc = '0;
    idx_dec = '0;
    for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
      if (!hit_inc && tbl_q[i].valid && (tbl_q[i].last != MAX_LINE) &&
          (train_line == tbl_q[i].last + 32'd1)) begin
        hit_inc = 1'b1;
        idx_inc = IDX_W'(i);
      end
      if (!hit_dec && tbl_q[i].valid && (tbl_q[i].last != 32'd0) &&
          (train_line == tbl_q[i].last - 32'd1)) begin
        hit_dec = 1'b1;
        idx_dec = IDX_W'(i);
      end
      if (tbl_q[i].valid && (train_line == tbl_q[i].last))
        hit_rep = 1'b1;
    end
  end

  always_comb begin
    train_wr  = 1'b0;
    alloc_adv = 1'b0;
    train_idx = '0;
    new_dir   = DIR_ASC;
    if (train_en) begin
      if (hit_inc) begin
        train_wr  = 1'b1;
        train_idx = idx_inc;
      end else if (hit_dec) begin
        train_wr  = 1'b1;
        train_idx = idx_dec;
        new_dir   = DIR_DESC;
      end else if (!hit_rep) begin
        train_wr  = 1'b1;
        train_idx = alloc_ptr_q;
        alloc_adv = 1'b1;
      end
    end
    train_blocked = step_blocked(train_line, new_dir, MAX_LINE);
    new_ent.valid = 1'b1;
    new_ent.dir   = new_dir;
    new_ent.last  = train_line;
    new_ent.next  = train_blocked ? train_line : step_line(train_line, new_dir);
    new_ent.cnt   = train_blocked ? CNT_LIMIT : 8'd0;
  end

  always_comb begin
    fill_blocked = step_blocked(tbl_q[infl_idx].next, infl_dir, MAX_LINE);
    fill_next    = fill_blocked ? tbl_q[infl_idx].next : step_line(tbl_q[infl_idx].next, infl_dir);
    fill_cnt     = fill_blocked ? CNT_LIMIT : (tbl_q[infl_idx].cnt + 8'd1);
  end

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_STREAMS; k++) begin
      cand = issue_ptr_q + IDX_W'(k);
      if (!sel_valid && tbl_q[cand].valid && (tbl_q[cand].cnt < CNT_LIMIT)) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
    sel_next = tbl_q[sel_idx].next;
    sel_dir  = tbl_q[sel_idx].dir;
  end

  // Training has priority over the fill update when both target the same entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < NUM_STREAMS; i++)
        tbl_q[i] <= '0;
      alloc_ptr_q <= '0;
      issue_ptr_q <= '0;
      stale_q     <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_STREAMS; i++) begin
        if (train_wr && (train_idx == IDX_W'(i))) begin
          tbl_q[i] <= new_ent;
        end else if (fill_en && !stale_q && (infl_idx == IDX_W'(i))) begin
          tbl_q[i].next <= fill_next;
          tbl_q[i].cnt  <= fill_cnt;
        end
      end
      if (alloc_adv)
        alloc_ptr_q <= alloc_ptr_q + IDX_ONE;
      if (fill_en)
        issue_ptr_q <= infl_idx + IDX_ONE;
      if (start)
        stale_q <= 1'b0;
      else if (issuing && train_wr && (train_idx == infl_idx))
        stale_q <= 1'b1;
    end
  end

`ifdef PREF_PERF_CNT_EN
  assign stale = stale_q;
`endif

endmodule

// File: rtl/stream_prefetcher.sv
// Multi-stream sequential prefetcher: issue FSM, memory request and cache fill interface.
// Define PREF_PERF_CNT_EN to add the pref_issued_cnt / pref_stale_cnt counters.
module stream_prefetcher
  import stream_pref_pkg::*;
#(
  parameter int unsigned NUM_STREAMS = 4,
  parameter int unsigned LIMIT       = 8,
  parameter int unsigned LINE_BYTES  = 32,
  parameter int unsigned LINE_W      = 256
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lsq_pmem_read_cla,
  input  logic                lsq_pmem_write_cla,
  input  logic                i_pmem_read_cla,
  input  logic                i_pmem_write_cla,
  input  logic [31:0]         lsq_pmem_address_cla,
  input  logic                arbiter_idle,
  stream_prefetcher_if.master mem
`ifdef PREF_PERF_CNT_EN
  ,
  output logic [31:0]         pref_issued_cnt,
  output logic [31:0]         pref_stale_cnt
`endif
);

  localparam int unsigned OFFSET = $clog2(LINE_BYTES);
  localparam int unsigned IDX_W  = $clog2(NUM_STREAMS);

  pref_state_e       state_q, state_d;
  logic              demand, any_req, start;
  logic [31:0]       train_line;
  logic              sel_valid, sel_dir;
  logic [IDX_W-1:0]  sel_idx;
  logic [31:0]       sel_next;
  logic [IDX_W-1:0]  idx_q;
  logic [31:0]       addr_q;
  logic              dir_q;
  logic [LINE_W-1:0] data_q;
`ifdef PREF_PERF_CNT_EN
  logic              stale;
`endif

  assign demand     = lsq_pmem_read_cla | lsq_pmem_write_cla;
  assign any_req    = demand | i_pmem_read_cla | i_pmem_write_cla;
  assign train_line = lsq_pmem_address_cla >> OFFSET;

  stream_table #(
    .NUM_STREAMS (NUM_STREAMS),
    .LIMIT       (LIMIT),
    .OFFSET      (OFFSET)
  ) u_table (
    .clk        (clk),
    .rst_n      (rst_n),
    .train_en   (demand),
    .train_line (train_line),
    .start      (start),
    .issuing    (state_q == ISSUE),
    .fill_en    (state_q == FILL),
    .infl_idx   (idx_q),
    .infl_dir   (dir_q),
    .sel_valid  (sel_valid),
    .sel_idx    (sel_idx),
    .sel_next   (sel_next),
    .sel_dir    (sel_dir)
`ifdef PREF_PERF_CNT_EN
    ,
    .stale      (stale)
`endif
  );

  always_comb begin
    state_d = state_q;
    start   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (arbiter_idle && !any_req && sel_valid) begin
          state_d = ISSUE;
          start   = 1'b1;
        end
      end
      ISSUE:   if (mem.pref_pmem_resp_cla) state_d = FILL;
      FILL:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      addr_q  <= '0;
      dir_q   <= DIR_ASC;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      if (start) begin
        idx_q  <= sel_idx;
        addr_q <= sel_next << OFFSET;
        dir_q  <= sel_dir;
      end
      if ((state_q == ISSUE) && mem.pref_pmem_resp_cla)
        data_q <= mem.pref_pmem_rdata_cla;
    end
  end

  // Outputs decode straight from state so an asynchronous reset drops the read at once.
  assign mem.pref_pmem_read_cla    = (state_q == ISSUE);
  assign mem.pref_pmem_write_cla   = 1'b0;
  assign mem.pref_pmem_address_cla = (state_q == ISSUE) ? addr_q : '0;
  assign mem.pref_pmem_wdata_cla   = '0;
  assign mem.pref_fill_valid       = (state_q == FILL);
  assign mem.pref_fill_addr        = (state_q == FILL) ? addr_q : '0;
  assign mem.pref_fill_data        = (state_q == FILL) ? data_q : '0;

`ifdef PREF_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pref_issued_cnt <= '0;
      pref_stale_cnt  <= '0;
    end else begin
      if (start && (pref_issued_cnt != '1))
        pref_issued_cnt <= pref_issued_cnt + 32'd1;
      if ((state_q == FILL) && stale && (pref_stale_cnt != '1))
        pref_stale_cnt <= pref_stale_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_stream_prefetcher.sv
// Scoreboard bench for stream_prefetcher: directed demand sequences, queued expected prefetches.
module tb_stream_prefetcher;
  localparam int unsigned LW = 256;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        lsq_rd = 1'b0, lsq_wr = 1'b0, i_rd = 1'b0, i_wr = 1'b0;
  logic [31:0] lsq_addr = '0;
  logic        arb_idle = 1'b1;
  int unsigned resp_delay = 0;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] exp_issue[$];
  logic [31:0] exp_fill[$];
`ifdef PREF_PERF_CNT_EN
  logic [31:0] issued_cnt, stale_cnt;
`endif

  always #5 clk = ~clk;

  stream_prefetcher_if #(.LINE_W(LW)) bus ();

  stream_prefetcher #(
    .NUM_STREAMS (4),
    .LIMIT       (8),
    .LINE_BYTES  (32),
    .LINE_W      (LW)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .lsq_pmem_read_cla    (lsq_rd),
    .lsq_pmem_write_cla   (lsq_wr),
    .i_pmem_read_cla      (i_rd),
    .i_pmem_write_cla     (i_wr),
    .lsq_pmem_address_cla (lsq_addr),
    .arbiter_idle         (arb_idle),
    .mem                  (bus)
`ifdef PREF_PERF_CNT_EN
    ,
    .pref_issued_cnt      (issued_cnt),
    .pref_stale_cnt       (stale_cnt)
`endif
  );

  function automatic logic [LW-1:0] line_data(input logic [31:0] a);
    return {8{a ^ 32'h5A5A_0000}};
  endfunction

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int unsigned n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic demand(input logic [31:0] a, input logic wr);
    lsq_rd   = ~wr;
    lsq_wr   = wr;
    lsq_addr = a;
    tick(1);
    lsq_rd = 1'b0;
    lsq_wr = 1'b0;
  endtask

  task automatic expect_pf(input logic [31:0] a);
    exp_issue.push_back(a);
    exp_fill.push_back(a);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    lsq_rd = 1'b0; lsq_wr = 1'b0; i_rd = 1'b0; i_wr = 1'b0;
    arb_idle = 1'b1;
    resp_delay = 0;
    tick(2);
    rst_n = 1'b1;
    tick(1);
  endtask

  task automatic drain(input int unsigned budget);
    int unsigned n = 0;
    while ((exp_issue.size() != 0 || exp_fill.size() != 0) && n < budget) begin
      tick(1);
      n++;
    end
    chk("pending_expectations", LW'(exp_issue.size() + exp_fill.size()), '0);
    exp_issue.delete();
    exp_fill.delete();
    tick(20);
  endtask

  task automatic wait_read(input logic [31:0] a, input int unsigned budget);
    int unsigned n = 0;
    while (!(bus.pref_pmem_read_cla && bus.pref_pmem_address_cla == a) && n < budget) begin
      tick(1);
      n++;
    end
    chk("wait_read_addr", LW'(bus.pref_pmem_address_cla), LW'(a));
  endtask

  // Memory model: answers a read resp_delay cycles after it appears.
  initial begin
    int unsigned wait_cnt = 0;
    bus.pref_pmem_resp_cla  = 1'b0;
    bus.pref_pmem_rdata_cla = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.pref_pmem_resp_cla = 1'b0;
      if (!rst_n || !bus.pref_pmem_read_cla) begin
        wait_cnt = 0;
      end else begin
        if (wait_cnt == resp_delay) begin
          bus.pref_pmem_resp_cla  = 1'b1;
          bus.pref_pmem_rdata_cla = line_data(bus.pref_pmem_address_cla);
        end
        wait_cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard on each new read request and each fill pulse.
  initial begin
    logic        prev_rd = 1'b0;
    logic [31:0] prev_addr = '0;
    logic [31:0] e;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (bus.pref_pmem_read_cla && !prev_rd) begin
          if (exp_issue.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_issue actual=%0h required=none", bus.pref_pmem_address_cla);
          end else begin
            e = exp_issue.pop_front();
            chk("issue_addr", LW'(bus.pref_pmem_address_cla), LW'(e));
          end
        end
        if (bus.pref_pmem_read_cla && prev_rd)
          chk("issue_addr_hold", LW'(bus.pref_pmem_address_cla), LW'(prev_addr));
        if (bus.pref_fill_valid) begin
          if (exp_fill.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_fill actual=%0h required=none", bus.pref_fill_addr);
          end else begin
            e = exp_fill.pop_front();
            chk("fill_addr", LW'(bus.pref_fill_addr), LW'(e));
            chk("fill_data", bus.pref_fill_data, line_data(e));
          end
        end
      end
      prev_rd   = bus.pref_pmem_read_cla;
      prev_addr = bus.pref_pmem_address_cla;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    tick(2);
    chk("rst_read", LW'(bus.pref_pmem_read_cla), '0);
    chk("rst_write", LW'(bus.pref_pmem_write_cla), '0);
    chk("rst_addr", LW'(bus.pref_pmem_address_cla), '0);
    chk("rst_wdata", bus.pref_pmem_wdata_cla, '0);
    chk("rst_fill_valid", LW'(bus.pref_fill_valid), '0);
    chk("rst_fill_addr", LW'(bus.pref_fill_addr), '0);
    chk("rst_fill_data", bus.pref_fill_data, '0);
    do_reset();

    // Ascending: 8 prefetches then the stream stops at LIMIT
    for (int unsigned k = 1; k <= 8; k++) expect_pf(32'h1000 + k * 32'h20);
    demand(32'h1000, 1'b0);
    drain(200);
    chk("write_tied_low", LW'(bus.pref_pmem_write_cla), '0);

    // Descending: 0x2000 then 0x1FE0 (writeback) turns the stream around
    do_reset();
    for (int unsigned k = 0; k < 8; k++) expect_pf(32'h1FC0 - k * 32'h20);
    demand(32'h2000, 1'b0);
    demand(32'h1FE0, 1'b1);
    drain(200);

    // Wrap guard: descending into line 0 must not issue
    do_reset();
    demand(32'h0020, 1'b0);
    demand(32'h0000, 1'b0);
    drain(10);

    // Multi-stream: fifth allocation replaces entry 0; issue rotates round-robin
    do_reset();
    for (int unsigned k = 1; k <= 8; k++) begin
      expect_pf(32'h2_0000 + k * 32'h20);
      expect_pf(32'h8000 + k * 32'h20);
      expect_pf(32'h4000 + k * 32'h20);
      expect_pf(32'hC000 + k * 32'h20);
    end
    demand(32'h1000, 1'b0);
    demand(32'h8000, 1'b0);
    demand(32'h4000, 1'b0);
    demand(32'hC000, 1'b0);
    demand(32'h2_0000, 1'b0);
    drain(600);

    // Blocking: i-side request and busy arbiter hold off issue; a demand cannot disturb ISSUE
    do_reset();
    demand(32'h3000, 1'b0);
    i_rd = 1'b1;
    tick(10);
    chk("blocked_by_i_read", LW'(bus.pref_pmem_read_cla), '0);
    i_rd = 1'b0;
    arb_idle = 1'b0;
    tick(6);
    chk("blocked_by_arbiter", LW'(bus.pref_pmem_read_cla), '0);
    resp_delay = 4;
    for (int unsigned k = 1; k <= 8; k++) expect_pf(32'h3000 + k * 32'h20);
    arb_idle = 1'b1;
    wait_read(32'h3020, 20);
    demand(32'h3000, 1'b0);
    chk("read_held_after_demand", LW'(bus.pref_pmem_read_cla), LW'(1));
    chk("addr_held_after_demand", LW'(bus.pref_pmem_address_cla), LW'(32'h3020));
    drain(400);

    // Stale: entry 0 reallocated to 0x9000 while its 0x1040 prefetch is outstanding
    do_reset();
    resp_delay = 3;
    expect_pf(32'h1020); expect_pf(32'h5020); expect_pf(32'h6020); expect_pf(32'h7020);
    expect_pf(32'h1040);
    for (int unsigned r = 0; r < 7; r++) begin
      expect_pf(32'h5040 + r * 32'h20);
      expect_pf(32'h6040 + r * 32'h20);
      expect_pf(32'h7040 + r * 32'h20);
      expect_pf(32'h9020 + r * 32'h20);
    end
    expect_pf(32'h9100);
    demand(32'h1000, 1'b0);
    demand(32'h5000, 1'b0);
    demand(32'h6000, 1'b0);
    demand(32'h7000, 1'b0);
    wait_read(32'h1040, 100);
    demand(32'h9000, 1'b0);
    drain(800);

    // Reset in the middle of ISSUE
    do_reset();
    resp_delay = 6;
    exp_issue.push_back(32'h1020);
    demand(32'h1000, 1'b0);
    wait_read(32'h1020, 20);
    tick(1);
    rst_n = 1'b0;
    #1;
    chk("async_rst_read_drop", LW'(bus.pref_pmem_read_cla), '0);
    chk("async_rst_addr", LW'(bus.pref_pmem_address_cla), '0);
    chk("async_rst_fill_valid", LW'(bus.pref_fill_valid), '0);
    tick(2);
    rst_n = 1'b1;
    resp_delay = 0;
    drain(5);
    // A surviving entry (last line 0x80) would turn 0x0FE0 into a descending stream
    for (int unsigned k = 0; k < 8; k++) expect_pf(32'h1000 + k * 32'h20);
    demand(32'h0FE0, 1'b0);
    drain(200);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
